// File: rtl/pooling_layer_max_unit.sv
// pooling_layer_max_unit
// Running IEEE-754 single-precision maximum over each pooling window. Each pooled
// result goes out under a valid/ready handshake. The block counts results per
// feature map and raises a sticky flag on framing errors.
// Optional build macro: POOL_NAN_CHECK_EN. When it is defined, a window that
// contains a NaN emits the canonical quiet NaN, and a sticky nan_seen port is added.
module pooling_layer_max_unit #(
    parameter int DATA_WIDTH        = 32,
    parameter int WINDOW_LEN        = 4,
    parameter int OUTPUTS_PER_FRAME = 144
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  frame_last,
    output logic                  frame_err
`ifdef POOL_NAN_CHECK_EN
    ,
    output logic                  nan_seen
`endif
);

    localparam int FCW = (OUTPUTS_PER_FRAME > 1) ? $clog2(OUTPUTS_PER_FRAME) : 1;
    localparam logic [7:0]     WIN_END   = 8'(WINDOW_LEN);
    localparam logic [FCW-1:0] FRAME_END = FCW'(OUTPUTS_PER_FRAME - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    state_t                state_q, state_d;
    logic [7:0]            elem_cnt_q, elem_cnt_d;
    logic [FCW-1:0]        frame_cnt_q, frame_cnt_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic                  err_q, err_d;
    logic                  accept;
    logic [7:0]            cnt_next;
    logic                  at_end;

    // IEEE-754 maximum on raw bit patterns. A positive operand beats a negative one,
    // so +0 beats -0. Between two positives the larger magnitude wins; between two
    // negatives the smaller magnitude wins.
    function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] r;
        if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
            r = a[DATA_WIDTH-1] ? b : a;
        else if (!a[DATA_WIDTH-1])
            r = (a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0]) ? a : b;
        else
            r = (a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0]) ? a : b;
        return r;
    endfunction

`ifdef POOL_NAN_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] QNAN = 32'h7FC0_0000;

    logic poison_q, poison_d;
    logic nan_q, nan_d;
    logic in_is_nan;

    function automatic logic is_nan(input logic [DATA_WIDTH-1:0] x);
        return (&x[30:23]) && (|x[22:0]);
    endfunction

    assign in_is_nan = is_nan(in_data);
`endif

    assign accept   = in_valid && (state_q != EMIT);
    // The element counter restarts from zero at the start of every window.
    assign cnt_next = ((state_q == IDLE) ? 8'd0 : elem_cnt_q) + 8'd1;
    assign at_end   = (cnt_next == WIN_END);

    // Next-state logic for the window FSM, the counters, the max register and the error flags.
    always_comb begin
        state_d     = state_q;
        elem_cnt_d  = elem_cnt_q;
        frame_cnt_d = frame_cnt_q;
        max_d       = max_q;
        err_d       = err_q;
`ifdef POOL_NAN_CHECK_EN
        poison_d    = poison_q;
        nan_d       = nan_q;
`endif
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    max_d      = (state_q == IDLE) ? in_data : fmax(max_q, in_data);
                    elem_cnt_d = cnt_next;
                    // A window closes on in_last or at full length. A window that is
                    // too short, or that is full without in_last, is a framing error.
                    state_d    = (in_last || at_end) ? EMIT : ACCUM;
                    if (in_last != at_end)
                        err_d = 1'b1;
`ifdef POOL_NAN_CHECK_EN
                    poison_d = ((state_q == IDLE) ? 1'b0 : poison_q) | in_is_nan;
                    nan_d    = nan_q | in_is_nan;
`endif
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    elem_cnt_d  = 8'd0;
                    frame_cnt_d = (frame_cnt_q == FRAME_END) ? '0 : frame_cnt_q + FCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers. All of them are cleared by reset, which drops any partial window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            elem_cnt_q  <= 8'd0;
            frame_cnt_q <= '0;
            max_q       <= '0;
            err_q       <= 1'b0;
`ifdef POOL_NAN_CHECK_EN
            poison_q    <= 1'b0;
            nan_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            elem_cnt_q  <= elem_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            max_q       <= max_d;
            err_q       <= err_d;
`ifdef POOL_NAN_CHECK_EN
            poison_q    <= poison_d;
            nan_q       <= nan_d;
`endif
        end
    end

    assign in_ready   = (state_q != EMIT);
    assign out_valid  = (state_q == EMIT);
    assign frame_last = (state_q == EMIT) && (frame_cnt_q == FRAME_END);
    assign frame_err  = err_q;
`ifdef POOL_NAN_CHECK_EN
    assign out_data   = poison_q ? QNAN : max_q;
    assign nan_seen   = nan_q;
`else
    assign out_data   = max_q;
`endif

endmodule
